// File: rtl/i2c_config_seq.sv
// Register-configuration sequencer: walks an entry ROM, issues I2C write commands
// over a valid/ready handshake, retries NACKed writes and replays a tail on HDMI interrupt.
module i2c_config_seq #(
    parameter int N_ENTRIES  = 42,
    parameter int IDX_W      = 6,
    parameter int REG_W      = 8,
    parameter int REINIT_IDX = 11,
    parameter int MAX_RETRY  = 3,
    parameter int GAP_CYCLES = 2500,
    parameter int AUTO_START = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  start,
    input  logic                  int_n,
    output logic [IDX_W-1:0]      rom_addr,
    input  logic [16+REG_W-1:0]   rom_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [16+REG_W-1:0]   m_data,
    input  logic                  m_done,
    input  logic                  m_nack,
    output logic                  busy,
    output logic                  ready,
    output logic                  error,
    output logic [7:0]            err_count,
    output logic [IDX_W-1:0]      cur_idx
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, GAP, DONE} state_t;

    localparam state_t             RST_STATE = (AUTO_START != 0) ? FETCH : IDLE;
    localparam logic [IDX_W:0]     N_END     = (IDX_W+1)'(N_ENTRIES);
    localparam logic [IDX_W-1:0]   REINIT    = IDX_W'(REINIT_IDX);
    localparam logic [15:0]        GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]         RETRY_MAX = 8'(MAX_RETRY);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rom_addr_q, rom_addr_d;
    logic                 m_valid_q, m_valid_d;
    logic [16+REG_W-1:0]  m_data_q, m_data_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;
    logic [7:0]           err_count_q, err_count_d;
    logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
    logic [7:0]           retry_q, retry_d;
    logic                 int_pend_q, int_pend_d;
    logic [15:0]          gap_cnt_q, gap_cnt_d;
    // adv=1: the GAP leads to the next entry (fresh fetch); adv=0: re-issue latched command
    logic                 adv_q, adv_d;
    logic [IDX_W:0]       next_idx;

    assign next_idx = {1'b0, cur_idx_q} + 1'b1;

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        error_d     = error_q;
        err_count_d = err_count_q;
        cur_idx_d   = cur_idx_q;
        retry_d     = retry_q;
        int_pend_d  = int_pend_q;
        gap_cnt_d   = gap_cnt_q;
        adv_d       = adv_q;

        if (state_q != IDLE && state_q != DONE && !int_n)
            int_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    cur_idx_d   = '0;
                    rom_addr_d  = '0;
                    err_count_d = '0;
                    error_d     = 1'b0;
                    ready_d     = 1'b0;
                    retry_d     = '0;
                    adv_d       = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                rom_addr_d = cur_idx_q;
                busy_d     = 1'b1;
                state_d    = LATCH;
            end
            LATCH: begin
                if (adv_q)
                    m_data_d = rom_data;
                m_valid_d = 1'b1;
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (m_done) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                    if (!m_nack) begin
                        retry_d = '0;
                        adv_d   = 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        adv_d   = 1'b0;
                    end else begin
                        if (err_count_q != 8'hFF)
                            err_count_d = err_count_q + 8'd1;
                        error_d = 1'b1;
                        retry_d = '0;
                        adv_d   = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (adv_q && next_idx == N_END) begin
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end else if (adv_q) begin
                        cur_idx_d  = next_idx[IDX_W-1:0];
                        rom_addr_d = next_idx[IDX_W-1:0];
                        state_d    = FETCH;
                    end else begin
                        state_d = LATCH;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                if (int_pend_q || !int_n) begin
                    // replay keeps the error record of the run it extends
                    int_pend_d = 1'b0;
                    cur_idx_d  = REINIT;
                    rom_addr_d = REINIT;
                    ready_d    = 1'b0;
                    retry_d    = '0;
                    adv_d      = 1'b1;
                    state_d    = FETCH;
                end else if (start) begin
                    cur_idx_d   = '0;
                    rom_addr_d  = '0;
                    err_count_d = '0;
                    error_d     = 1'b0;
                    ready_d     = 1'b0;
                    retry_d     = '0;
                    adv_d       = 1'b1;
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= RST_STATE;
            rom_addr_q  <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
            cur_idx_q   <= '0;
            retry_q     <= '0;
            int_pend_q  <= 1'b0;
            gap_cnt_q   <= '0;
            adv_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            cur_idx_q   <= cur_idx_d;
            retry_q     <= retry_d;
            int_pend_q  <= int_pend_d;
            gap_cnt_q   <= gap_cnt_d;
            adv_q       <= adv_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign err_count = err_count_q;
    assign cur_idx   = cur_idx_q;

endmodule

// File: tb/tb_i2c_config_seq.sv
// Bench for i2c_config_seq: randomized I2C master responder plus an entry-level
// reference model of which commands each run must issue.
module tb_i2c_config_seq;

    localparam int N      = 42;
    localparam int IDX_W  = 6;
    localparam int REG_W  = 8;
    localparam int CW     = 16 + REG_W;
    localparam int REINIT = 11;
    localparam int MAXR   = 3;
    localparam int GAP    = 4;
    localparam int N2     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic              int_n = 1'b1;
    logic [IDX_W-1:0]  rom_addr, cur_idx;
    logic [CW-1:0]     rom_data, m_data;
    logic              m_valid, busy, ready, error;
    logic              m_ready = 1'b1;
    logic              m_done = 1'b0;
    logic              m_nack = 1'b0;
    logic [7:0]        err_count;

    logic              start2 = 1'b0;
    logic              int_n2 = 1'b1;
    logic [IDX_W-1:0]  rom_addr2, cur_idx2;
    logic [CW-1:0]     rom_data2, m_data2;
    logic              m_valid2, busy2, ready2, error2;
    logic              m_ready2 = 1'b1;
    logic              m_done2 = 1'b0;
    logic              m_nack2 = 1'b0;
    logic [7:0]        err_count2;

    i2c_config_seq #(.N_ENTRIES(N), .IDX_W(IDX_W), .REG_W(REG_W), .REINIT_IDX(REINIT),
                     .MAX_RETRY(MAXR), .GAP_CYCLES(GAP), .AUTO_START(1)) u_dut (
        .iCLK(clk), .iRST_N(rst_n), .start(start), .int_n(int_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_done(m_done), .m_nack(m_nack),
        .busy(busy), .ready(ready), .error(error), .err_count(err_count), .cur_idx(cur_idx)
    );

    i2c_config_seq #(.N_ENTRIES(N2), .IDX_W(IDX_W), .REG_W(REG_W), .REINIT_IDX(1),
                     .MAX_RETRY(MAXR), .GAP_CYCLES(2), .AUTO_START(0)) u_dut_ms (
        .iCLK(clk), .iRST_N(rst_n), .start(start2), .int_n(int_n2),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
        .m_done(m_done2), .m_nack(m_nack2),
        .busy(busy2), .ready(ready2), .error(error2), .err_count(err_count2), .cur_idx(cur_idx2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Table ROM with one cycle of read latency; reg field holds the entry index
    logic [CW-1:0] rom [N];
    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data2 <= rom[rom_addr2];
    end

    logic [CW-1:0] issued[$];
    logic [CW-1:0] issued2[$];
    int            att[N];
    int            nack_plan[N];
    bit            rand_ready = 1'b0;
    int            stall_left = 0;
    int            stall_seen = 0;
    bit            seen_valid2 = 1'b0;

    // Master for the main instance: NACKs an entry while its attempt count is below its plan
    initial begin : master
        int            idx;
        int            done_timer;
        bit            pend_nack;
        bit            have_hold;
        logic [CW-1:0] hold_data;
        done_timer = 0;
        pend_nack  = 1'b0;
        have_hold  = 1'b0;
        hold_data  = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            m_nack = 1'b0;
            if (!rst_n) begin
                done_timer = 0;
                have_hold  = 1'b0;
                m_ready    = 1'b1;
            end else begin
                if (done_timer > 0) begin
                    done_timer--;
                    if (done_timer == 0) begin
                        m_done = 1'b1;
                        m_nack = pend_nack;
                    end
                end
                if (m_valid && stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                end else begin
                    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (m_valid) begin
                    if (have_hold) chk("hold_data", m_data, hold_data);
                    hold_data = m_data;
                    have_hold = !m_ready;
                    if (m_ready) begin
                        idx = int'(m_data[15:8]);
                        pend_nack = att[idx] < nack_plan[idx];
                        att[idx]++;
                        issued.push_back(m_data);
                        done_timer = $urandom_range(1, 4);
                    end
                end else begin
                    have_hold = 1'b0;
                end
            end
        end
    end

    initial begin : master2
        int t2;
        t2 = 0;
        forever begin
            @(negedge clk);
            m_done2 = 1'b0;
            if (!rst_n) begin
                t2 = 0;
            end else begin
                if (t2 > 0) begin
                    t2--;
                    if (t2 == 0) m_done2 = 1'b1;
                end
                if (m_valid2) begin
                    issued2.push_back(m_data2);
                    seen_valid2 = 1'b1;
                    t2 = 2;
                end
            end
        end
    end

    logic [CW-1:0] exp_q[$];
    int            exp_err;
    int            mdl_att[N];

    // Entry i is offered up to MAXR+1 times; it stops at the first ACK, else counts as abandoned
    task automatic model_run(input int first);
        for (int i = first; i < N; i++) begin
            int a;
            bit acked;
            a = 0;
            acked = 1'b0;
            while (!acked && a <= MAXR) begin
                exp_q.push_back(rom[i]);
                acked = (mdl_att[i] >= nack_plan[i]);
                mdl_att[i]++;
                a++;
            end
            if (!acked && exp_err < 255) exp_err++;
        end
    endtask

    task automatic new_run();
        issued.delete();
        exp_q.delete();
        exp_err = 0;
        for (int i = 0; i < N; i++) begin
            att[i]     = 0;
            mdl_att[i] = 0;
        end
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, issued.size(), exp_q.size());
        for (int i = 0; i < issued.size() && i < exp_q.size(); i++)
            chk(tag, issued[i], exp_q[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int expn);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20000 && !ok; c++) begin
            @(negedge clk);
            if (issued.size() >= expn && ready && !busy) ok = 1'b1;
        end
        chk({tag, "_done"}, ok, 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_entry(input string tag, input int reg_idx);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20000 && !ok; c++) begin
            @(posedge clk);
            #2;
            if (issued.size() > 0 && !m_valid &&
                int'(issued[issued.size()-1][15:8]) == reg_idx) ok = 1'b1;
        end
        chk({tag, "_reach"}, ok, 1);
    endtask

    task automatic chk_final(input string tag, input int exp_e);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, (exp_e > 0) ? 1 : 0);
        chk({tag, "_errcnt"}, err_count, exp_e);
    endtask

    initial begin : main
        for (int i = 0; i < N; i++) begin
            rom[i] = {8'($urandom), 8'(i), 8'($urandom)};
            nack_plan[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_cur_idx", cur_idx, 0);
        chk("rst_busy2", busy2, 0);

        // Run A: auto start from reset release, all ACK, m_ready high
        new_run();
        model_run(0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_valid_c1", m_valid, 0);
        @(posedge clk); #1;
        chk("first_valid_c2", m_valid, 1);
        chk("first_data", m_data, rom[0]);
        wait_done("runA", exp_q.size());
        cmp_seq("runA");
        chk_final("runA", 0);
        chk("ms_no_auto", seen_valid2, 0);

        // Run B: entry 2 NACKs twice, entry 1 always NACKs, random m_ready, ignored start
        new_run();
        nack_plan[1] = 100;
        nack_plan[2] = 2;
        rand_ready = 1'b1;
        model_run(0);
        pulse_start();
        wait_entry("runB_e5", 5);
        pulse_start();
        wait_done("runB", exp_q.size());
        cmp_seq("runB");
        chk_final("runB", exp_err);

        // Run C: random NACK plan, 20-cycle stall on first command, interrupt at entry 5
        new_run();
        for (int i = 0; i < N; i++) nack_plan[i] = $urandom_range(0, 5);
        nack_plan[1] = 100;
        stall_left = 20;
        stall_seen = 0;
        model_run(0);
        model_run(REINIT);
        pulse_start();
        wait_entry("runC_e5", 5);
        @(negedge clk);
        int_n = 1'b0;
        @(negedge clk);
        int_n = 1'b1;
        wait_done("runC", exp_q.size());
        cmp_seq("runC");
        chk("runC_stall", stall_seen, 20);
        chk_final("runC", exp_err);

        // Run D: reset while waiting on entry 7, then auto restart from entry 0
        new_run();
        for (int i = 0; i < N; i++) nack_plan[i] = 0;
        pulse_start();
        wait_entry("runD_e7", 7);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cur_idx", cur_idx, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_err", err_count, 0);
        repeat (3) @(negedge clk);
        new_run();
        model_run(0);
        rst_n = 1'b1;
        wait_done("runD", exp_q.size());
        cmp_seq("runD");
        chk_final("runD", 0);

        // Manual-start instance: idle until start, then entries 0..N2-1 in order
        chk("ms_idle_valid", seen_valid2, 0);
        chk("ms_idle_busy", busy2, 0);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        begin
            bit ok;
            ok = 1'b0;
            for (int c = 0; c < 2000 && !ok; c++) begin
                @(negedge clk);
                if (ready2 && !busy2 && issued2.size() >= N2) ok = 1'b1;
            end
            chk("ms_done", ok, 1);
        end
        repeat (10) @(negedge clk);
        chk("ms_len", issued2.size(), N2);
        for (int i = 0; i < issued2.size() && i < N2; i++) chk("ms_seq", issued2[i], rom[i]);
        chk("ms_error", error2, 0);
        chk("ms_errcnt", err_count2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
